// File: rtl/mem_ss_rd_interleave.sv
// Read-path channel interleaver.
// Each host AR burst is steered to one memory channel, chosen by the address
// interleave bits. Read data is returned to the host in request order. An
// order FIFO records the channel of every accepted burst, and a 2-entry skid
// stage registers the host R channel.
module mem_ss_rd_interleave #(
   parameter int CHANNELS    = 4,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 512,
   parameter int ID_WIDTH    = 9,
   parameter int LEN_WIDTH   = 8,
   parameter int INTLV_BYTES = 4096,
   parameter int ORDER_DEPTH = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               s_arvalid,
   output logic                               s_arready,
   input  logic [ADDR_WIDTH-1:0]              s_araddr,
   input  logic [ID_WIDTH-1:0]                s_arid,
   input  logic [LEN_WIDTH-1:0]               s_arlen,
   output logic                               s_rvalid,
   input  logic                               s_rready,
   output logic [DATA_WIDTH-1:0]              s_rdata,
   output logic [ID_WIDTH-1:0]                s_rid,
   output logic [1:0]                         s_rresp,
   output logic                               s_rlast,
   output logic [CHANNELS-1:0]                m_arvalid,
   input  logic [CHANNELS-1:0]                m_arready,
   output logic [CHANNELS*ADDR_WIDTH-1:0]     m_araddr,
   output logic [CHANNELS*ID_WIDTH-1:0]       m_arid,
   output logic [CHANNELS*LEN_WIDTH-1:0]      m_arlen,
   input  logic [CHANNELS-1:0]                m_rvalid,
   output logic [CHANNELS-1:0]                m_rready,
   input  logic [CHANNELS*DATA_WIDTH-1:0]     m_rdata,
   input  logic [CHANNELS*ID_WIDTH-1:0]       m_rid,
   input  logic [CHANNELS*2-1:0]              m_rresp,
   input  logic [CHANNELS-1:0]                m_rlast,
   output logic [$clog2(ORDER_DEPTH+1)-1:0]   outstanding,
   output logic                               err_cross
);

   localparam int CH_BITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 0;
   localparam int SEL_W      = (CH_BITS > 0) ? CH_BITS : 1;
   localparam int IB         = $clog2(INTLV_BYTES);
   localparam int BEAT_BYTES = DATA_WIDTH / 8;
   localparam int BB         = $clog2(BEAT_BYTES);
   localparam int GRAN_BEATS = (INTLV_BYTES > BEAT_BYTES) ? (INTLV_BYTES / BEAT_BYTES) : 1;
   localparam int PTR_W      = $clog2(ORDER_DEPTH);
   localparam int CNT_W      = $clog2(ORDER_DEPTH + 1);

   localparam logic [SEL_W-1:0]      SEL_MASK = SEL_W'(CHANNELS - 1);
   localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(INTLV_BYTES - 1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [ID_WIDTH-1:0]   id;
      logic [1:0]            resp;
      logic                  last;
   } beat_t;

   // AR decode
   logic [SEL_W-1:0]      ar_sel;
   logic [CHANNELS-1:0]   ar_onehot;
   logic [ADDR_WIDTH-1:0] addr_low;
   logic [ADDR_WIDTH-1:0] addr_high;
   logic [ADDR_WIDTH-1:0] local_addr;
   logic [ADDR_WIDTH-1:0] beat_idx;
   logic [ADDR_WIDTH:0]   cross_sum;
   logic                  ar_cross;
   logic                  ar_push;

   // Order FIFO
   logic [SEL_W-1:0] ofifo_mem_q [ORDER_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ofifo_full;
   logic             ofifo_empty;
   logic [SEL_W-1:0] head;
   logic             r_pop;

   // R path and skid stage
   logic [CHANNELS-1:0] head_onehot;
   logic                in_vld;
   beat_t               in_beat;
   logic                out_vld_q, out_vld_d;
   beat_t               out_beat_q, out_beat_d;
   logic                skid_vld_q, skid_vld_d;
   beat_t               skid_beat_q, skid_beat_d;
   logic                out_fire;
   logic                err_cross_q, err_cross_d;

   // Decode the channel select, the channel-local address and the granule-crossing flag
   always_comb begin
      // NOTE: every signal gets a value on every path through an always_comb, otherwise a latch is inferred.
      ar_sel     = SEL_W'(s_araddr >> IB) & SEL_MASK;
      addr_low   = s_araddr & LOW_MASK;
      addr_high  = (s_araddr >> (IB + CH_BITS)) << IB;
      local_addr = addr_high | addr_low;
      beat_idx   = addr_low >> BB;
      cross_sum  = {1'b0, beat_idx} + {{(ADDR_WIDTH + 1 - LEN_WIDTH){1'b0}}, s_arlen};
      ar_cross   = (cross_sum >= (ADDR_WIDTH + 1)'(GRAN_BEATS));
      for (int c = 0; c < CHANNELS; c++) begin
         ar_onehot[c] = (ar_sel == SEL_W'(c));
      end
   end

   // Combinational AR steering: valid never looks at ready
   always_comb begin
      ofifo_full  = (cnt_q == CNT_W'(ORDER_DEPTH));
      ofifo_empty = (cnt_q == '0);
      m_arvalid   = ar_onehot & {CHANNELS{s_arvalid & ~ofifo_full}};
      s_arready   = ~ofifo_full & |(m_arready & ar_onehot);
      ar_push     = s_arvalid & s_arready;
      m_araddr    = {CHANNELS{local_addr}};
      m_arid      = {CHANNELS{s_arid}};
      m_arlen     = {CHANNELS{s_arlen}};
   end

   // Select the head channel's R beat and grant it only when the skid stage has room
   always_comb begin
      head     = ofifo_mem_q[rd_ptr_q];
      m_rready = '0;
      in_beat  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         head_onehot[c] = (head == SEL_W'(c));
         if (head_onehot[c]) begin
            in_beat.data = m_rdata[c*DATA_WIDTH +: DATA_WIDTH];
            in_beat.id   = m_rid[c*ID_WIDTH +: ID_WIDTH];
            in_beat.resp = m_rresp[c*2 +: 2];
            in_beat.last = m_rlast[c];
         end
      end
      if (!ofifo_empty && !skid_vld_q) begin
         m_rready = head_onehot;
      end
      in_vld = |(m_rvalid & m_rready);
      r_pop  = in_vld & in_beat.last;
   end

   // Order FIFO pointer and occupancy update; pointers wrap naturally at the power-of-2 depth
   always_comb begin
      wr_ptr_d    = wr_ptr_q + PTR_W'(ar_push);
      rd_ptr_d    = rd_ptr_q + PTR_W'(r_pop);
      cnt_d       = cnt_q + CNT_W'(ar_push) - CNT_W'(r_pop);
      err_cross_d = ar_push & ar_cross;
   end

   // Two-entry skid: the output register refills from the skid slot first, then from the channel
   always_comb begin
      out_fire    = out_vld_q & s_rready;
      out_vld_d   = out_vld_q;
      out_beat_d  = out_beat_q;
      skid_vld_d  = skid_vld_q;
      skid_beat_d = skid_beat_q;
      if (!out_vld_q || out_fire) begin
         out_vld_d  = skid_vld_q | in_vld;
         out_beat_d = skid_vld_q ? skid_beat_q : in_beat;
         skid_vld_d = 1'b0;
      end else if (in_vld) begin
         skid_vld_d  = 1'b1;
         skid_beat_d = in_beat;
      end
   end

   // Control state with synchronous reset
   always_ff @(posedge clk) begin
      // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         out_vld_q   <= 1'b0;
         skid_vld_q  <= 1'b0;
         err_cross_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         out_vld_q   <= out_vld_d;
         skid_vld_q  <= skid_vld_d;
         err_cross_q <= err_cross_d;
      end
   end

   // Datapath storage: order FIFO entries and skid payloads
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; the valid flags and the FIFO count decide whether its content is used.
      if (ar_push) begin
         ofifo_mem_q[wr_ptr_q] <= ar_sel;
      end
      out_beat_q  <= out_beat_d;
      skid_beat_q <= skid_beat_d;
   end

   assign s_rvalid    = out_vld_q;
   assign s_rdata     = out_beat_q.data;
   assign s_rid       = out_beat_q.id;
   assign s_rresp     = out_beat_q.resp;
   assign s_rlast     = out_beat_q.last;
   assign outstanding = cnt_q;
   assign err_cross   = err_cross_q;

endmodule

// File: tb/tb_mem_ss_rd_interleave.sv
// Directed bench for mem_ss_rd_interleave.
// Covers routing, in-order return across channels, a full order FIFO,
// host backpressure, granule crossing and a reset in the middle of traffic.
// Inputs change at posedge+1 (host) and posedge+2 (channel responders).
// Outputs are sampled mid-cycle or 1 ns before the next edge.
module tb_mem_ss_rd_interleave;

   localparam int CH     = 4;
   localparam int AW     = 32;
   localparam int DW     = 512;
   localparam int IW     = 9;
   localparam int LW     = 8;
   localparam int IBYTES = 4096;
   localparam int OD     = 16;
   localparam int CW     = $clog2(OD + 1);

   logic              clk;
   logic              rst;
   logic              s_arvalid;
   logic              s_arready;
   logic [AW-1:0]     s_araddr;
   logic [IW-1:0]     s_arid;
   logic [LW-1:0]     s_arlen;
   logic              s_rvalid;
   logic              s_rready;
   logic [DW-1:0]     s_rdata;
   logic [IW-1:0]     s_rid;
   logic [1:0]        s_rresp;
   logic              s_rlast;
   logic [CH-1:0]     m_arvalid;
   logic [CH-1:0]     m_arready;
   logic [CH*AW-1:0]  m_araddr;
   logic [CH*IW-1:0]  m_arid;
   logic [CH*LW-1:0]  m_arlen;
   logic [CH-1:0]     m_rvalid;
   logic [CH-1:0]     m_rready;
   logic [CH*DW-1:0]  m_rdata;
   logic [CH*IW-1:0]  m_rid;
   logic [CH*2-1:0]   m_rresp;
   logic [CH-1:0]     m_rlast;
   logic [CW-1:0]     outstanding;
   logic              err_cross;

   mem_ss_rd_interleave #(
      .CHANNELS    (CH),
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .ID_WIDTH    (IW),
      .LEN_WIDTH   (LW),
      .INTLV_BYTES (IBYTES),
      .ORDER_DEPTH (OD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .s_arvalid   (s_arvalid),
      .s_arready   (s_arready),
      .s_araddr    (s_araddr),
      .s_arid      (s_arid),
      .s_arlen     (s_arlen),
      .s_rvalid    (s_rvalid),
      .s_rready    (s_rready),
      .s_rdata     (s_rdata),
      .s_rid       (s_rid),
      .s_rresp     (s_rresp),
      .s_rlast     (s_rlast),
      .m_arvalid   (m_arvalid),
      .m_arready   (m_arready),
      .m_araddr    (m_araddr),
      .m_arid      (m_arid),
      .m_arlen     (m_arlen),
      .m_rvalid    (m_rvalid),
      .m_rready    (m_rready),
      .m_rdata     (m_rdata),
      .m_rid       (m_rid),
      .m_rresp     (m_rresp),
      .m_rlast     (m_rlast),
      .outstanding (outstanding),
      .err_cross   (err_cross)
   );

   typedef struct packed {
      logic [31:0]   data;
      logic [IW-1:0] id;
      logic [1:0]    resp;
      logic          last;
   } beat_t;

   beat_t         ch_q [CH][$];
   beat_t         rx_q [$];
   int            rx_cyc [$];
   int            ch_log [$];
   logic [CH-1:0] ch_fire;
   int            cyc;
   int            n_checks;
   int            n_pass;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic beat_t mk(input int data, input int id, input int resp, input bit last);
      beat_t b;
      b.data = 32'(data);
      b.id   = IW'(id);
      b.resp = 2'(resp);
      b.last = last;
      return b;
   endfunction

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic flush_all();
      for (int c = 0; c < CH; c++) ch_q[c].delete();
      rx_q.delete();
      rx_cyc.delete();
      ch_log.delete();
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      s_arvalid = 1'b0;
      s_rready  = 1'b0;
      m_arready = '1;
      flush_all();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Drive one AR, check its routing before the edge, return at posedge+1 after the accept
   task automatic ar_issue(input logic [31:0] addr, input int id, input int len,
                           input int exp_ch, input logic [31:0] exp_local);
      s_arvalid = 1'b1;
      s_araddr  = addr;
      s_arid    = IW'(id);
      s_arlen   = LW'(len);
      #5;
      check("ar_route", 64'(m_arvalid), 64'(1 << exp_ch));
      check("ar_local", 64'(m_araddr[exp_ch*AW +: AW]), 64'(exp_local));
      check("ar_ready", 64'(s_arready), 64'd1);
      tick();
      s_arvalid = 1'b0;
   endtask

   // Monitor: samples handshakes 1 ns before each rising edge
   initial begin
      beat_t b;
      ch_fire = '0;
      cyc     = 0;
      forever begin
         @(negedge clk);
         #4;
         cyc++;
         ch_fire = m_rvalid & m_rready;
         if (!rst) begin
            for (int c = 0; c < CH; c++) begin
               if (ch_fire[c]) ch_log.push_back(c);
            end
            if (s_rvalid && s_rready) begin
               b.data = s_rdata[31:0];
               b.id   = s_rid;
               b.resp = s_rresp;
               b.last = s_rlast;
               rx_q.push_back(b);
               rx_cyc.push_back(cyc);
            end
         end
      end
   end

   // Channel responders: present the queue head, retire it after a handshake
   initial begin
      m_rvalid = '0;
      m_rdata  = '0;
      m_rid    = '0;
      m_rresp  = '0;
      m_rlast  = '0;
      forever begin
         @(posedge clk);
         #2;
         for (int c = 0; c < CH; c++) begin
            if (ch_fire[c] && ch_q[c].size() > 0) void'(ch_q[c].pop_front());
            if (ch_q[c].size() > 0) begin
               m_rvalid[c]            = 1'b1;
               m_rdata[c*DW +: DW]    = DW'(ch_q[c][0].data);
               m_rid[c*IW +: IW]      = ch_q[c][0].id;
               m_rresp[c*2 +: 2]      = ch_q[c][0].resp;
               m_rlast[c]             = ch_q[c][0].last;
            end else begin
               m_rvalid[c]            = 1'b0;
               m_rdata[c*DW +: DW]    = '0;
               m_rid[c*IW +: IW]      = '0;
               m_rresp[c*2 +: 2]      = '0;
               m_rlast[c]             = 1'b0;
            end
         end
      end
   end

   // Watchdog
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "timeout");
   end

   initial begin
      beat_t exp_ooo [6];
      beat_t exp_bp  [8];
      int    exp_log [6];

      n_checks  = 0;
      n_pass    = 0;
      rst       = 1'b1;
      s_arvalid = 1'b0;
      s_araddr  = '0;
      s_arid    = '0;
      s_arlen   = '0;
      s_rready  = 1'b0;
      m_arready = '1;
      tick();

      // ---------------- reset state ----------------
      do_reset();
      #5;
      check("rst_rvalid", 64'(s_rvalid), 64'd0);
      check("rst_outstanding", 64'(outstanding), 64'd0);
      check("rst_err_cross", 64'(err_cross), 64'd0);
      check("rst_rready", 64'(m_rready), 64'd0);
      check("rst_arready", 64'(s_arready), 64'd1);
      tick();

      // ---------------- routing and local address ----------------
      ar_issue(32'h0000_0000, 1, 0, 0, 32'h0000_0000);
      ar_issue(32'h0000_1000, 2, 0, 1, 32'h0000_0000);
      ar_issue(32'h0000_2000, 3, 0, 2, 32'h0000_0000);
      ar_issue(32'h0000_3000, 4, 0, 3, 32'h0000_0000);
      ar_issue(32'h0000_4000, 5, 0, 0, 32'h0000_1000);
      ar_issue(32'h0001_5ABC, 6, 0, 1, 32'h0000_5ABC);
      #5;
      check("route_outstanding", 64'(outstanding), 64'd6);
      check("route_arid_pass", 64'(m_arid[1*IW +: IW]), 64'd6);
      tick();

      // ---------------- out-of-order channel return ----------------
      do_reset();
      s_rready = 1'b1;
      ch_q[0].push_back(mk(32'h0A0, 7, 2, 1'b0));
      ch_q[0].push_back(mk(32'h0A1, 7, 2, 1'b1));
      tick();
      tick();
      #5;
      check("empty_stall_rready", 64'(m_rready), 64'd0);
      check("empty_stall_rvalid", 64'(s_rvalid), 64'd0);
      tick();
      ar_issue(32'h0000_2000, 5, 3, 2, 32'h0);
      ar_issue(32'h0000_0000, 7, 1, 0, 32'h0);
      #5;
      check("ooo_head_ch2", 64'(m_rready), 64'h4);
      check("ooo_no_early_r", 64'(s_rvalid), 64'd0);
      tick();
      for (int k = 0; k < 4; k++) ch_q[2].push_back(mk(32'h2C0 + k, 5, 0, k == 3));
      repeat (12) tick();
      exp_ooo[0] = mk(32'h2C0, 5, 0, 1'b0);
      exp_ooo[1] = mk(32'h2C1, 5, 0, 1'b0);
      exp_ooo[2] = mk(32'h2C2, 5, 0, 1'b0);
      exp_ooo[3] = mk(32'h2C3, 5, 0, 1'b1);
      exp_ooo[4] = mk(32'h0A0, 7, 2, 1'b0);
      exp_ooo[5] = mk(32'h0A1, 7, 2, 1'b1);
      exp_log    = '{2, 2, 2, 2, 0, 0};
      check("ooo_rx_count", 64'(rx_q.size()), 64'd6);
      for (int i = 0; i < 6 && i < rx_q.size(); i++) check($sformatf("ooo_beat%0d", i), 64'(rx_q[i]), 64'(exp_ooo[i]));
      check("ooo_ch_count", 64'(ch_log.size()), 64'd6);
      for (int i = 0; i < 6 && i < ch_log.size(); i++) check($sformatf("ooo_ch_order%0d", i), 64'(ch_log[i]), 64'(exp_log[i]));
      check("ooo_drained", 64'(outstanding), 64'd0);

      // ---------------- full order FIFO ----------------
      do_reset();
      for (int i = 0; i < OD; i++) ar_issue(32'(i * 32'h1000), i, 0, i % 4, 32'((i / 4) * 32'h1000));
      #5;
      check("full_outstanding", 64'(outstanding), 64'd16);
      check("full_arready", 64'(s_arready), 64'd0);
      tick();
      s_arvalid = 1'b1;
      s_araddr  = 32'h0000_0000;
      s_arid    = IW'(99);
      s_arlen   = '0;
      ch_q[0].push_back(mk(32'hF00, 0, 0, 1'b1));
      #5;
      check("pop_cycle_arready", 64'(s_arready), 64'd0);
      check("pop_cycle_arvalid", 64'(m_arvalid), 64'd0);
      check("pop_cycle_rready", 64'(m_rready), 64'h1);
      tick();
      #5;
      check("after_pop_outstanding", 64'(outstanding), 64'd15);
      check("after_pop_arready", 64'(s_arready), 64'd1);
      tick();
      s_arvalid = 1'b0;
      #5;
      check("refill_outstanding", 64'(outstanding), 64'd16);
      check("refill_rvalid", 64'(s_rvalid), 64'd1);
      tick();

      // ---------------- backpressure ----------------
      do_reset();
      ar_issue(32'h0000_1000, 1, 3, 1, 32'h0);
      ar_issue(32'h0000_3000, 3, 3, 3, 32'h0);
      for (int k = 0; k < 4; k++) ch_q[1].push_back(mk(32'h1B0 + k, 1, 0, k == 3));
      for (int k = 0; k < 4; k++) ch_q[3].push_back(mk(32'h3B0 + k, 3, 0, k == 3));
      for (int k = 0; k < 24; k++) begin
         s_rready = (k % 3 == 0);
         tick();
      end
      s_rready = 1'b1;
      repeat (6) tick();
      for (int k = 0; k < 4; k++) exp_bp[k]     = mk(32'h1B0 + k, 1, 0, k == 3);
      for (int k = 0; k < 4; k++) exp_bp[k + 4] = mk(32'h3B0 + k, 3, 0, k == 3);
      check("bp_rx_count", 64'(rx_q.size()), 64'd8);
      for (int i = 0; i < 8 && i < rx_q.size(); i++) check($sformatf("bp_beat%0d", i), 64'(rx_q[i]), 64'(exp_bp[i]));

      // ---------------- full throughput ----------------
      do_reset();
      s_rready = 1'b1;
      ar_issue(32'h0000_2000, 2, 7, 2, 32'h0);
      for (int k = 0; k < 8; k++) ch_q[2].push_back(mk(32'h2D0 + k, 2, 0, k == 7));
      repeat (14) tick();
      check("tp_rx_count", 64'(rx_q.size()), 64'd8);
      if (rx_q.size() == 8) begin
         check("tp_span", 64'(rx_cyc[7] - rx_cyc[0]), 64'd7);
         check("tp_last_beat", 64'(rx_q[7]), 64'(mk(32'h2D7, 2, 0, 1'b1)));
      end

      // ---------------- granule crossing ----------------
      do_reset();
      ar_issue(32'h0000_0FC0, 4, 3, 0, 32'h0000_0FC0);
      #5;
      check("cross_pulse", 64'(err_cross), 64'd1);
      tick();
      #5;
      check("cross_pulse_end", 64'(err_cross), 64'd0);
      tick();
      ar_issue(32'h0000_0F80, 4, 1, 0, 32'h0000_0F80);
      #5;
      check("nocross_pulse", 64'(err_cross), 64'd0);
      tick();
      #5;
      check("nocross_after", 64'(err_cross), 64'd0);
      tick();

      // ---------------- reset mid-operation ----------------
      do_reset();
      ar_issue(32'h0000_0000, 10, 3, 0, 32'h0);
      ar_issue(32'h0000_1000, 11, 3, 1, 32'h0);
      ar_issue(32'h0000_2000, 12, 3, 2, 32'h0);
      for (int k = 0; k < 4; k++) ch_q[0].push_back(mk(32'h0E0 + k, 10, 0, k == 3));
      ch_q[1].push_back(mk(32'h1E0, 11, 0, 1'b1));
      repeat (4) tick();
      #5;
      check("pre_rst_rvalid", 64'(s_rvalid), 64'd1);
      check("pre_rst_skid_full", 64'(m_rready), 64'd0);
      check("pre_rst_outstanding", 64'(outstanding), 64'd3);
      check("pre_rst_held_data", 64'(s_rdata[31:0]), 64'h0E0);
      tick();
      rst = 1'b1;
      ch_q[0].delete();
      ch_q[2].delete();
      tick();
      rst       = 1'b0;
      m_arready = 4'b1011;
      s_arvalid = 1'b1;
      s_araddr  = 32'h0000_2000;
      #5;
      check("post_rst_rvalid", 64'(s_rvalid), 64'd0);
      check("post_rst_outstanding", 64'(outstanding), 64'd0);
      check("post_rst_rready", 64'(m_rready), 64'd0);
      check("post_rst_arready_ch2", 64'(s_arready), 64'd0);
      #1;
      s_araddr = 32'h0000_1000;
      #1;
      check("post_rst_arready_ch1", 64'(s_arready), 64'd1);
      s_arvalid = 1'b0;
      tick();
      #5;
      check("stale_beat_stall", 64'(m_rready), 64'd0);
      check("stale_no_rvalid", 64'(s_rvalid), 64'd0);
      check("stale_outstanding", 64'(outstanding), 64'd0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
